// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the single datapath
// Optional jump support is compiled in with the CTRL_JUMP_EN macro.
module mc_control_unit #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_start,
  input  logic                    c_i_halt,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  output logic                    c_o_ce,
  output logic                    c_o_RegDst,
  output logic                    c_o_RegWrite,
  output logic                    c_o_ALUSrc,
  output logic                    c_o_Branch,
  output logic                    c_o_MemRead,
  output logic                    c_o_MemWrite,
  output logic                    c_o_MemtoReg,
  output logic                    c_o_busy,
  output logic                    c_o_illegal,
  output logic [CNT_WIDTH-1:0]    c_o_retired
);

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
`ifdef CTRL_JUMP_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic                    illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]    retired_q, retired_d;
  logic                    retire;

  function automatic logic op_legal(input logic [OPCODE_WIDTH-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: ok = 1'b1;
`ifdef CTRL_JUMP_EN
      OP_J:                                    ok = 1'b1;
`endif
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State, latched opcode, sticky trap flag and retire counter; reset overrides everything.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state sequencing; the final state of each instruction raises retire.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_i_start && !c_i_halt) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = c_i_opcode;
        if (op_legal(c_i_opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode_q)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          default:           retire  = 1'b1;  // beq and j finish in EXEC
        endcase
      end
      S_MEM: begin
        if (opcode_q == OP_LW) state_d = S_WB;
        else                   retire  = 1'b1;
      end
      S_WB:    retire  = 1'b1;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = c_i_halt ? S_IDLE : S_FETCH;
    retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;
  end

  // Moore output decode from the state register and latched opcode only.
  always_comb begin
    c_o_ce       = 1'b0;
    c_o_RegDst   = 1'b0;
    c_o_RegWrite = 1'b0;
    c_o_ALUSrc   = 1'b0;
    c_o_Branch   = 1'b0;
    c_o_MemRead  = 1'b0;
    c_o_MemWrite = 1'b0;
    c_o_MemtoReg = 1'b0;
    case (state_q)
      S_FETCH: c_o_ce = 1'b1;
      S_EXEC: begin
        c_o_ALUSrc = (opcode_q == OP_LW) || (opcode_q == OP_SW) || (opcode_q == OP_ADDI);
`ifdef CTRL_JUMP_EN
        c_o_Branch = (opcode_q == OP_BEQ) || (opcode_q == OP_J);
`else
        c_o_Branch = (opcode_q == OP_BEQ);
`endif
      end
      S_MEM: begin
        c_o_MemRead  = (opcode_q == OP_LW);
        c_o_MemWrite = (opcode_q != OP_LW);
      end
      S_WB: begin
        c_o_RegWrite = 1'b1;
        c_o_RegDst   = (opcode_q == OP_RTYPE);
        c_o_MemtoReg = (opcode_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign c_o_busy    = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign c_o_illegal = illegal_q;
  assign c_o_retired = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit (32-bit and 4-bit counter instances)
module tb_mc_control_unit;

  localparam logic [7:0] O_NONE  = 8'h00;  // {ce,RegDst,RegWrite,ALUSrc,Branch,MemRead,MemWrite,MemtoReg}
  localparam logic [7:0] O_FETCH = 8'h80;
  localparam logic [7:0] O_ALU   = 8'h10;
  localparam logic [7:0] O_BR    = 8'h08;
  localparam logic [7:0] O_MRD   = 8'h04;
  localparam logic [7:0] O_MWR   = 8'h02;
  localparam logic [7:0] O_WBR   = 8'h60;
  localparam logic [7:0] O_WBI   = 8'h20;
  localparam logic [7:0] O_WBL   = 8'h21;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BAD  = 6'h3f;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic [5:0] opcode = OP_BAD;

  logic        a_ce, a_rd, a_rw, a_as, a_br, a_mr, a_mw, a_m2r, a_busy, a_ill;
  logic [31:0] a_ret;
  logic        b_ce, b_rd, b_rw, b_as, b_br, b_mr, b_mw, b_m2r, b_busy, b_ill;
  logic [3:0]  b_ret;

  typedef struct {
    logic [7:0]  strb;
    logic        busy;
    logic        ill;
    logic [31:0] ret;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .c_clk(clk), .c_rst(rst), .c_i_start(start), .c_i_halt(halt), .c_i_opcode(opcode),
    .c_o_ce(a_ce), .c_o_RegDst(a_rd), .c_o_RegWrite(a_rw), .c_o_ALUSrc(a_as),
    .c_o_Branch(a_br), .c_o_MemRead(a_mr), .c_o_MemWrite(a_mw), .c_o_MemtoReg(a_m2r),
    .c_o_busy(a_busy), .c_o_illegal(a_ill), .c_o_retired(a_ret)
  );

  mc_control_unit #(.CNT_WIDTH(4)) dut4 (
    .c_clk(clk), .c_rst(rst), .c_i_start(start), .c_i_halt(halt), .c_i_opcode(opcode),
    .c_o_ce(b_ce), .c_o_RegDst(b_rd), .c_o_RegWrite(b_rw), .c_o_ALUSrc(b_as),
    .c_o_Branch(b_br), .c_o_MemRead(b_mr), .c_o_MemWrite(b_mw), .c_o_MemtoReg(b_m2r),
    .c_o_busy(b_busy), .c_o_illegal(b_ill), .c_o_retired(b_ret)
  );

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic h, input logic [5:0] op,
                     input logic [7:0] strb, input logic busy, input logic ill,
                     input int unsigned ret, input string name);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; halt = h; opcode = op;
    e.strb = strb; e.busy = busy; e.ill = ill; e.ret = ret; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare every presented output cycle against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t       e;
    logic [7:0] sa, sb;
    #1;
    if (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      sa = {a_ce, a_rd, a_rw, a_as, a_br, a_mr, a_mw, a_m2r};
      sb = {b_ce, b_rd, b_rw, b_as, b_br, b_mr, b_mw, b_m2r};
      checks++;
      if (sa !== e.strb || sb !== e.strb || a_busy !== e.busy || b_busy !== e.busy ||
          a_ill !== e.ill || b_ill !== e.ill || a_ret !== e.ret || b_ret !== e.ret[3:0]) begin
        errors++;
        $display("FAIL %s: got strb=%h/%h busy=%b/%b ill=%b/%b ret=%0d/%0d, want strb=%h busy=%b ill=%b ret=%0d/%0d",
                 e.name, sa, sb, a_busy, b_busy, a_ill, b_ill, a_ret, b_ret,
                 e.strb, e.busy, e.ill, e.ret, e.ret[3:0]);
      end
    end
  end

  initial begin
    int unsigned r;
    // reset and idle behaviour
    cyc(1, 0, 0, OP_BAD, O_NONE, 0, 0, 0, "reset");
    cyc(1, 1, 0, OP_BAD, O_NONE, 0, 0, 0, "reset_beats_start");
    cyc(0, 1, 1, OP_BAD, O_NONE, 0, 0, 0, "start_with_halt_stays_idle");
    // R-type
    cyc(0, 1, 0, OP_BAD, O_FETCH, 1, 0, 0, "r_fetch");
    cyc(0, 1, 0, OP_BAD, O_NONE,  1, 0, 0, "r_decode");
    cyc(0, 0, 0, OP_R,   O_NONE,  1, 0, 0, "r_exec");
    cyc(0, 0, 0, OP_BAD, O_WBR,   1, 0, 0, "r_wb");
    cyc(0, 0, 0, OP_BAD, O_FETCH, 1, 0, 1, "r_retire_fetch");
    // lw
    cyc(0, 0, 0, OP_BAD, O_NONE,  1, 0, 1, "lw_decode");
    cyc(0, 0, 0, OP_LW,  O_ALU,   1, 0, 1, "lw_exec");
    cyc(0, 0, 0, OP_BAD, O_MRD,   1, 0, 1, "lw_mem");
    cyc(0, 0, 0, OP_BAD, O_WBL,   1, 0, 1, "lw_wb");
    cyc(0, 0, 0, OP_BAD, O_FETCH, 1, 0, 2, "lw_retire");
    // sw; early halt is not the retiring cycle and must be ignored
    cyc(0, 0, 1, OP_BAD, O_NONE,  1, 0, 2, "sw_decode");
    cyc(0, 0, 0, OP_SW,  O_ALU,   1, 0, 2, "sw_exec");
    cyc(0, 0, 0, OP_BAD, O_MWR,   1, 0, 2, "sw_mem");
    cyc(0, 0, 0, OP_BAD, O_FETCH, 1, 0, 3, "sw_retire");
    // beq with halt in EXEC
    cyc(0, 0, 0, OP_BAD, O_NONE,  1, 0, 3, "beq_decode");
    cyc(0, 0, 0, OP_BEQ, O_BR,    1, 0, 3, "beq_exec");
    cyc(0, 0, 1, OP_BAD, O_NONE,  0, 0, 4, "beq_halt_idle");
    cyc(0, 0, 0, OP_BAD, O_NONE,  0, 0, 4, "idle_hold");
    // twelve addi: 4-bit counter wraps from 15 to 0
    cyc(0, 1, 0, OP_BAD, O_FETCH, 1, 0, 4, "addi_fetch");
    r = 4;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, OP_BAD,  O_NONE, 1, 0, r, "addi_decode");
      cyc(0, 0, 0, OP_ADDI, O_ALU,  1, 0, r, "addi_exec");
      cyc(0, 0, 0, OP_BAD,  O_WBI,  1, 0, r, "addi_wb");
      r = r + 1;
      if (i == 11) cyc(0, 0, 1, OP_BAD, O_NONE,  0, 0, r, "addi_wrap_halt");
      else         cyc(0, 0, 0, OP_BAD, O_FETCH, 1, 0, r, "addi_retire");
    end
    // reset in the middle of a load
    cyc(0, 1, 0, OP_BAD, O_FETCH, 1, 0, 16, "lw2_fetch");
    cyc(0, 0, 0, OP_BAD, O_NONE,  1, 0, 16, "lw2_decode");
    cyc(0, 0, 0, OP_LW,  O_ALU,   1, 0, 16, "lw2_exec");
    cyc(0, 0, 0, OP_BAD, O_MRD,   1, 0, 16, "lw2_mem");
    cyc(1, 0, 0, OP_BAD, O_NONE,  0, 0, 0,  "reset_in_mem");
    cyc(0, 0, 0, OP_BAD, O_NONE,  0, 0, 0,  "idle_after_reset");
    // illegal opcode
    cyc(0, 1, 0, OP_BAD, O_FETCH, 1, 0, 0, "bad_fetch");
    cyc(0, 0, 0, OP_BAD, O_NONE,  1, 0, 0, "bad_decode");
    cyc(0, 0, 0, OP_BAD, O_NONE,  0, 1, 0, "trap_entry");
    cyc(0, 1, 0, OP_BAD, O_NONE,  0, 1, 0, "trap_ignores_start");
    cyc(1, 0, 0, OP_BAD, O_NONE,  0, 0, 0, "trap_reset");
    // jump
    cyc(0, 1, 0, OP_BAD, O_FETCH, 1, 0, 0, "j_fetch");
    cyc(0, 0, 0, OP_BAD, O_NONE,  1, 0, 0, "j_decode");
`ifdef CTRL_JUMP_EN
    cyc(0, 0, 0, OP_J,   O_BR,    1, 0, 0, "j_exec");
    cyc(0, 0, 1, OP_BAD, O_NONE,  0, 0, 1, "j_retire_halt");
`else
    cyc(0, 0, 0, OP_J,   O_NONE,  0, 1, 0, "j_trap");
    cyc(1, 0, 0, OP_BAD, O_NONE,  0, 0, 0, "j_trap_reset");
`endif
    repeat (4) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
